riscv_fetch: RTL and testbench

- Instruction-fetch stage directly upstream of the decode stage.
- Owns the PC, issues single-outstanding reads to instruction memory and buffers returned words in a small prefetch FIFO.
- Presents {inst_data, inst_address, inst_ready, inst_count} to decode.
- Honours the pipeline stall/flush and redirects to a branch/trap target on flush.

---
 rtl/riscv_fetch_pkg.sv | 23 ++
 rtl/riscv_fetch_buffer.sv | 66 ++++++
 rtl/riscv_fetch.sv | 129 ++++++++++++
 tb/tb_riscv_fetch.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_fetch_pkg.sv
// rtl/riscv_fetch_pkg.sv - shared types and constants for the instruction fetch stage
package riscv_fetch_pkg;

    localparam int FETCH_ADDR_W = 32;
    localparam int FETCH_DATA_W = 32;
    localparam logic [FETCH_ADDR_W-1:0] FETCH_PC_INC = 32'd4;

    typedef enum logic [1:0] {
        ST_RESET   = 2'd0,
        ST_REQ     = 2'd1,
        ST_HOLD    = 2'd2,
        ST_DISCARD = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic [FETCH_ADDR_W-1:0] addr;
        logic [FETCH_DATA_W-1:0] data;
        logic                    exc;
    } fetch_entry_t;

    localparam int FETCH_ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/riscv_fetch_buffer.sv
// rtl/riscv_fetch_buffer.sv - prefetch FIFO of fetch entries with clear
// Clear and push in the same cycle leave exactly the pushed entry.
module riscv_fetch_buffer
    import riscv_fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_clear,
    input  logic [FETCH_ENTRY_W-1:0] i_entry,
    output logic [FETCH_ENTRY_W-1:0] o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [CNT_W-1:0]         o_count
);

    logic [FETCH_ENTRY_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]         r_wr_ptr;
    logic [PTR_W-1:0]         r_rd_ptr;
    logic [CNT_W-1:0]         r_count;
    logic                     w_push;
    logic                     w_pop;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);

    always_ff @(posedge clk) begin
        if (i_clear) begin
            if (i_push) begin
                r_mem[0] <= i_entry;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= i_entry;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= PTR_W'(i_push);
            r_count  <= CNT_W'(i_push);
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

endmodule

// File: rtl/riscv_fetch.sv
// rtl/riscv_fetch.sv - fetch stage: PC, single-outstanding imem reads, prefetch FIFO
// Optional misaligned-target exception: RISCV_FETCH_MISALIGN_EXC_EN.
module riscv_fetch
    import riscv_fetch_pkg::*;
#(
    parameter int                         INST_ADDR_WIDTH = 32,
    parameter int                         INST_DATA_WIDTH = 32,
    parameter logic [INST_ADDR_WIDTH-1:0] RESET_PC        = 32'h0000_0200,
    parameter int                         FIFO_DEPTH      = 2
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       stall,
    input  logic                       flush,
    input  logic [INST_ADDR_WIDTH-1:0] branch_target,
    output logic                       imem_read,
    output logic [INST_ADDR_WIDTH-1:0] imem_address,
    input  logic [INST_DATA_WIDTH-1:0] imem_data,
    input  logic                       imem_ack,
    output logic [INST_DATA_WIDTH-1:0] inst_data,
    output logic [INST_ADDR_WIDTH-1:0] inst_address,
    output logic                       inst_ready,
    output logic                       inst_count,
    output logic                       fetch_exception
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
`ifdef RISCV_FETCH_MISALIGN_EXC_EN
    localparam bit EXC_EN = 1'b1;
`else
    localparam bit EXC_EN = 1'b0;
`endif

    fetch_state_e               r_state;
    fetch_state_e               w_state_next;
    logic [INST_ADDR_WIDTH-1:0] r_pc;
    logic                       r_exc_stop;
    logic [INST_ADDR_WIDTH-1:0] w_target;
    logic                       w_misalign;
    logic                       w_req_ack;
    logic                       w_push;
    logic                       w_pop;
    logic                       w_full;
    logic                       w_empty;
    logic                       w_full_after;
    logic [CNT_W-1:0]           w_count;
    fetch_entry_t               w_entry;
    fetch_entry_t               w_head;

    // Without the exception feature the low target bits are simply dropped.
    assign w_target   = EXC_EN ? branch_target : (branch_target & ~INST_ADDR_WIDTH'(3));
    assign w_misalign = EXC_EN && flush && (branch_target[1:0] != 2'b00);
    assign w_full_after = (w_count == CNT_W'(FIFO_DEPTH - 1)) && !w_pop;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_RESET;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (flush) begin
            if (((r_state == ST_REQ) || (r_state == ST_DISCARD)) && !imem_ack) begin
                w_state_next = ST_DISCARD;
            end else if (w_misalign) begin
                w_state_next = ST_HOLD;
            end else begin
                w_state_next = ST_REQ;
            end
        end else begin
            case (r_state)
                ST_RESET:   w_state_next = ST_REQ;
                ST_REQ:     if (imem_ack && w_full_after) w_state_next = ST_HOLD;
                ST_HOLD:    if (w_pop && !r_exc_stop) w_state_next = ST_REQ;
                ST_DISCARD: if (imem_ack) w_state_next = r_exc_stop ? ST_HOLD : ST_REQ;
                default:    w_state_next = ST_RESET;
            endcase
        end
    end

    always_comb begin
        imem_read    = (r_state == ST_REQ) && !w_full;
        w_req_ack    = (r_state == ST_REQ) && imem_ack && !flush;
        w_pop        = !w_empty && !stall && !flush;
        w_push       = w_req_ack || w_misalign;
        w_entry.addr = FETCH_ADDR_W'(w_misalign ? w_target : r_pc);
        w_entry.data = w_misalign ? '0 : FETCH_DATA_W'(imem_data);
        w_entry.exc  = w_misalign;
    end

    // A misaligned target parks fetching until the next flush.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pc       <= RESET_PC;
            r_exc_stop <= 1'b0;
        end else if (flush) begin
            r_pc       <= w_target;
            r_exc_stop <= w_misalign;
        end else if (w_req_ack) begin
            r_pc <= r_pc + INST_ADDR_WIDTH'(FETCH_PC_INC);
        end
    end

    riscv_fetch_buffer #(
        .DEPTH (FIFO_DEPTH)
    ) u_buffer (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_clear (flush),
        .i_entry (w_entry),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign imem_address    = r_pc;
    assign inst_ready      = !w_empty;
    assign inst_count      = !w_empty;
    assign inst_data       = INST_DATA_WIDTH'(w_head.data);
    assign inst_address    = INST_ADDR_WIDTH'(w_head.addr);
    assign fetch_exception = EXC_EN && !w_empty && w_head.exc;

endmodule

// File: tb/tb_riscv_fetch.sv
// tb/tb_riscv_fetch.sv - randomized bench for riscv_fetch against a queue-based reference model
module tb_riscv_fetch;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int DEPTH = 2;
    localparam logic [AW-1:0] RPC = 32'h0000_0200;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          stall = 1'b0;
    logic          flush = 1'b0;
    logic [AW-1:0] branch_target = '0;
    logic [DW-1:0] imem_data = '0;
    logic          imem_ack = 1'b0;
    logic          imem_read;
    logic [AW-1:0] imem_address;
    logic [DW-1:0] inst_data;
    logic [AW-1:0] inst_address;
    logic          inst_ready;
    logic          inst_count;
    logic          fetch_exception;

    riscv_fetch #(
        .INST_ADDR_WIDTH (AW),
        .INST_DATA_WIDTH (DW),
        .RESET_PC        (RPC),
        .FIFO_DEPTH      (DEPTH)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .stall           (stall),
        .flush           (flush),
        .branch_target   (branch_target),
        .imem_read       (imem_read),
        .imem_address    (imem_address),
        .imem_data       (imem_data),
        .imem_ack        (imem_ack),
        .inst_data       (inst_data),
        .inst_address    (inst_address),
        .inst_ready      (inst_ready),
        .inst_count      (inst_count),
        .fetch_exception (fetch_exception)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail = 0;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          exc;
    } m_entry_t;

    m_entry_t      mq[$];
    logic [AW-1:0] m_pc = RPC;
    bit            m_started = 1'b0;
    bit            m_disc = 1'b0;
    bit            m_stop = 1'b0;

    bit            mem_pend = 1'b0;
    int            mem_lat = 0;
    int            fix_lat = 0;
    logic [AW-1:0] mem_addr = '0;
    bit            force_en = 1'b0;
    logic [DW-1:0] force_data = '0;
    int            ack_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_read();
        return m_started && !m_disc && !m_stop && (mq.size() < DEPTH);
    endfunction

    // Model: FIFO as a queue; a request is active whenever fetching is live and there is room.
    task automatic model_step();
        bit            rd;
        bit            mis;
        logic [AW-1:0] t;
        m_entry_t      e;
        rd  = m_read();
        mis = 1'b0;
        t   = branch_target;
        if (flush) begin
`ifdef RISCV_FETCH_MISALIGN_EXC_EN
            mis = (t[1:0] != 2'b00);
`else
            t[1:0] = 2'b00;
`endif
            m_disc = (rd || m_disc) && !imem_ack;
            mq.delete();
            m_pc = t;
            m_stop = mis;
            m_started = 1'b1;
            if (mis) begin
                e.addr = t;
                e.data = '0;
                e.exc  = 1'b1;
                mq.push_back(e);
            end
        end else if (!m_started) begin
            m_started = 1'b1;
        end else begin
            if (mq.size() > 0 && !stall) begin
                void'(mq.pop_front());
            end
            if (rd && imem_ack) begin
                e.addr = m_pc;
                e.data = imem_data;
                e.exc  = 1'b0;
                mq.push_back(e);
                m_pc = m_pc + 32'd4;
            end else if (m_disc && imem_ack) begin
                m_disc = 1'b0;
            end
        end
    endtask

    initial forever begin
        @(posedge clk or negedge reset_n);
        if (!reset_n) begin
            mq.delete();
            m_pc = RPC;
            m_started = 1'b0;
            m_disc = 1'b0;
            m_stop = 1'b0;
        end else begin
            model_step();
        end
    end

    initial forever begin
        @(negedge clk);
        if (reset_n) begin
            check("imem_read", imem_read, m_read());
            if (m_read()) check("imem_address", imem_address, m_pc);
            check("inst_ready", inst_ready, mq.size() > 0);
            check("inst_count", inst_count, mq.size() > 0);
            if (mq.size() > 0) begin
                check("inst_address", inst_address, mq[0].addr);
                check("inst_data", inst_data, mq[0].data);
                check("fetch_exception", fetch_exception, mq[0].exc);
            end else begin
                check("fetch_exception_idle", fetch_exception, 1'b0);
            end
        end
    end

    // Advance one cycle and play the memory side for the new cycle.
    task automatic step();
        @(posedge clk);
        #1;
        if (mem_pend && imem_read) check("imem_address_stable", imem_address, mem_addr);
        if (!mem_pend && imem_read) begin
            mem_pend = 1'b1;
            mem_addr = imem_address;
            mem_lat  = (fix_lat >= 0) ? fix_lat : int'($urandom_range(0, 3));
        end
        if (mem_pend && mem_lat == 0) begin
            imem_ack  = 1'b1;
            imem_data = force_en ? force_data : $urandom;
            mem_pend  = 1'b0;
            ack_cnt++;
        end else begin
            imem_ack  = 1'b0;
            imem_data = $urandom;
            if (mem_pend) mem_lat--;
        end
    endtask

    // Returns in the first cycle after release; a pending read is acked then and must be ignored.
    task automatic do_reset();
        @(posedge clk);
        #1;
        reset_n  = 1'b0;
        stall    = 1'b0;
        flush    = 1'b0;
        imem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        ack_cnt = 0;
        if (mem_pend) begin
            imem_ack  = 1'b1;
            imem_data = $urandom;
            mem_pend  = 1'b0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] bt;
        int            k;

        fix_lat = 0;
        do_reset();
        check("rst_read", imem_read, 1'b0);
        check("rst_ready", inst_ready, 1'b0);
        step();
        check("t1_c2_read", imem_read, 1'b1);
        check("t1_c2_addr", imem_address, 32'h200);
        step();
        check("t1_c3_addr", imem_address, 32'h204);
        check("t1_c3_ready", inst_ready, 1'b1);
        check("t1_c3_head", inst_address, 32'h200);
        step();
        check("t1_c4_addr", imem_address, 32'h208);
        check("t1_c4_head", inst_address, 32'h204);

        do_reset();
        stall = 1'b1;
        repeat (5) step();
        check("t2_hold_read", imem_read, 1'b0);
        check("t2_pushes", ack_cnt, 2);
        check("t2_head", inst_address, 32'h200);
        stall = 1'b0;
        step();
        check("t2_c7_head", inst_address, 32'h204);
        check("t2_c7_read", imem_read, 1'b1);
        check("t2_c7_addr", imem_address, 32'h208);

        fix_lat = 3;
        do_reset();
        repeat (3) step();
        check("t3_c4_addr", imem_address, 32'h200);
        check("t3_c4_ready", inst_ready, 1'b0);
        repeat (2) step();
        check("t3_c6_head", inst_address, 32'h200);
        check("t3_c6_addr", imem_address, 32'h204);
        repeat (4) step();
        check("t3_c10_addr", imem_address, 32'h208);
        step();
        flush = 1'b1;
        branch_target = 32'h1000;
        force_en = 1'b1;
        force_data = 32'h0000_DEAD;
        step();
        flush = 1'b0;
        check("t3_flush_empty", inst_ready, 1'b0);
        check("t3_flush_noread", imem_read, 1'b0);
        step();
        force_en = 1'b0;
        step();
        check("t3_redirect_read", imem_read, 1'b1);
        check("t3_redirect_addr", imem_address, 32'h1000);
        k = 0;
        while (!inst_ready && k < 20) begin
            step();
            k++;
        end
        check("t3_wait_ready", inst_ready, 1'b1);
        check("t3_target_head", inst_address, 32'h1000);

        fix_lat = 0;
        do_reset();
        step();
        flush = 1'b1;
        stall = 1'b1;
        branch_target = 32'h1000;
        step();
        flush = 1'b0;
        stall = 1'b0;
        check("t4_dropped", inst_ready, 1'b0);
        check("t4_read", imem_read, 1'b1);
        check("t4_addr", imem_address, 32'h1000);

        do_reset();
        step();
        flush = 1'b1;
        branch_target = 32'h1002;
        step();
        flush = 1'b0;
        stall = 1'b1;
`ifdef RISCV_FETCH_MISALIGN_EXC_EN
        check("t5_noread", imem_read, 1'b0);
        check("t5_ready", inst_ready, 1'b1);
        check("t5_head", inst_address, 32'h1002);
        check("t5_exc", fetch_exception, 1'b1);
        check("t5_data", inst_data, 32'h0);
`else
        check("t5_read", imem_read, 1'b1);
        check("t5_addr", imem_address, 32'h1000);
        check("t5_ready", inst_ready, 1'b0);
        check("t5_exc", fetch_exception, 1'b0);
`endif
        stall = 1'b0;

        fix_lat = -1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            stall = ($urandom_range(0, 9) < 3);
            flush = ($urandom_range(0, 19) == 0);
            case ($urandom_range(0, 3))
                0:       bt = $urandom;
                1:       bt = 32'hFFFF_FFE0 | 32'($urandom_range(0, 31));
                default: bt = $urandom & 32'h0000_FFFC;
            endcase
            branch_target = bt;
            step();
        end
        flush = 1'b0;
        stall = 1'b0;
        repeat (10) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
